alu_seq: RTL and testbench

Parametrised successor to the 16-bit combinational ALU.
- Registers every result and the status byte.
- Adds a valid/ready operand handshake.
- Adds iterative multi-cycle multiply and divide alongside the single-cycle ops.
- Sits in the CPU execute stage between register-file read and write-back; the stage stalls on in_ready low.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_muldiv_iter.sv | 79 +++++++
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, status-bit and FSM definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_MULH = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_REM  = 4'd12;

  localparam int unsigned ST_Z   = 0;
  localparam int unsigned ST_N   = 1;
  localparam int unsigned ST_C   = 2;
  localparam int unsigned ST_V   = 3;
  localparam int unsigned ST_DZ  = 4;
  localparam int unsigned ST_ILL = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider; one bit per clock, WIDTH bits total.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,     // 0: multiply, 1: divide
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             op_q;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    cnt;

  logic             it_op;
  logic [WIDTH-1:0] it_hi, it_lo, it_d;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] nx_hi, nx_lo;

  // The first iteration runs on the load edge so the result is ready WIDTH edges after start.
  always_comb begin
    it_op    = start ? op : op_q;
    it_hi    = start ? '0 : hi;
    it_lo    = start ? (op ? x : y) : lo;
    it_d     = start ? (op ? y : x) : opnd;
    mul_sum  = {1'b0, it_hi} + (it_lo[0] ? {1'b0, it_d} : '0);
    div_sh   = {it_hi, it_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, it_d};
    div_ok   = (div_sh >= {1'b0, it_d});
    if (it_op) begin
      nx_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      nx_lo = {it_lo[WIDTH-2:0], div_ok};
    end else begin
      nx_hi = mul_sum[WIDTH:1];
      nx_lo = {mul_sum[0], it_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 1'b0;
      opnd <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      lo   <= '0;
      hi   <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        op_q <= op;
        opnd <= op ? y : x;
        cnt  <= CW'(WIDTH - 2);
        busy <= 1'b1;
        lo   <= nx_lo;
        hi   <= nx_hi;
      end else if (busy) begin
        lo <= nx_lo;
        hi <= nx_hi;
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready operand handshake and optional iterative multiply/divide.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MULDIV_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             imm,
  input  logic [WIDTH-1:0] imm_val,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [7:0]       status_reg
);

  localparam int unsigned SW = $clog2(WIDTH);

  state_t           state, next_state;
  logic [3:0]       func_q;
  logic [WIDTH-1:0] b_sel;
  logic             accept, is_md, is_dz, is_mc, legal;

  logic [WIDTH-1:0] sc_res, mc_res, out_d;
  logic [7:0]       sc_status, mc_status, status_d;
  logic             sc_c, sc_v, valid_d, ready_d;
  logic [WIDTH:0]   sum_w, shl_w, shr_w;
  logic signed [WIDTH:0] sra_w;
  logic [SW-1:0]    amt;

  logic             md_start, md_op, md_busy, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  function automatic logic [7:0] mk_status(input logic [WIDTH-1:0] r, input logic c,
                                           input logic v, input logic dz);
    logic [7:0] s;
    s        = '0;
    s[ST_Z]  = (r == '0);
    s[ST_N]  = r[WIDTH-1];
    s[ST_C]  = c;
    s[ST_V]  = v;
    s[ST_DZ] = dz;
    return s;
  endfunction

  assign b_sel  = imm ? imm_val : b;
  assign accept = in_valid && in_ready;
  assign amt    = b_sel[SW-1:0];
  assign is_md  = (MULDIV_EN != 0) && (func >= OP_MUL) && (func <= OP_REM);
  assign is_dz  = is_md && ((func == OP_DIV) || (func == OP_REM)) && (b_sel == '0);
  assign is_mc  = is_md && !is_dz;
  assign legal  = (func <= OP_SRA) || is_md;
  assign md_op  = (func == OP_DIV) || (func == OP_REM);

  // Single-cycle datapath, including divide-by-zero and illegal opcodes.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sum_w  = '0;
    shl_w  = {1'b0, a} << amt;
    shr_w  = {a, 1'b0} >> amt;
    sra_w  = $signed({a, 1'b0}) >>> amt;
    case (func)
      OP_PASS: sc_res = b_sel;
      OP_ADD: begin
        sum_w  = {1'b0, a} + {1'b0, b_sel};
        sc_res = sum_w[WIDTH-1:0];
        sc_c   = sum_w[WIDTH];
        sc_v   = (a[WIDTH-1] == b_sel[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum_w  = {1'b0, a} + {1'b0, ~b_sel} + (WIDTH+1)'(1);
        sc_res = sum_w[WIDTH-1:0];
        sc_c   = sum_w[WIDTH];
        sc_v   = (a[WIDTH-1] != b_sel[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_res = a & b_sel;
      OP_OR:  sc_res = a | b_sel;
      OP_XOR: sc_res = a ^ b_sel;
      OP_SHL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_w[WIDTH:1];
        sc_c   = shr_w[0];
      end
      OP_SRA: begin
        sc_res = sra_w[WIDTH:1];
        sc_c   = sra_w[0];
      end
      OP_DIV:  sc_res = '1;
      OP_REM:  sc_res = a;
      default: sc_res = '0;
    endcase
    if (!legal) begin
      sc_res    = '0;
      sc_status = 8'h20;
    end else begin
      sc_status = mk_status(sc_res, sc_c, sc_v, is_dz);
    end
  end

  // Completion of an iterative operation selects the half requested at accept.
  always_comb begin
    mc_res    = ((func_q == OP_MULH) || (func_q == OP_REM)) ? md_hi : md_lo;
    mc_status = mk_status(mc_res,
                          ((func_q == OP_MUL) || (func_q == OP_MULH)) && (md_hi != '0),
                          1'b0, 1'b0);
  end

  always_comb begin
    next_state = state;
    out_d      = out;
    status_d   = status_reg;
    valid_d    = 1'b0;
    md_start   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mc) begin
            md_start   = 1'b1;
            next_state = BUSY;
          end else begin
            out_d    = sc_res;
            status_d = sc_status;
            valid_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (md_done && !md_busy) begin
          next_state = IDLE;
          out_d      = mc_res;
          status_d   = mc_status;
          valid_d    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    ready_d = (next_state == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      func_q     <= OP_PASS;
      out        <= '0;
      status_reg <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= next_state;
      out        <= out_d;
      status_reg <= status_d;
      out_valid  <= valid_d;
      in_ready   <= ready_d;
      if (md_start) func_q <= func;
    end
  end

  if (MULDIV_EN != 0) begin : g_md
    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk   (clk),
      .rst   (rst),
      .start (md_start),
      .op    (md_op),
      .x     (a),
      .y     (b_sel),
      .busy  (md_busy),
      .done  (md_done),
      .lo    (md_lo),
      .hi    (md_hi)
    );
  end else begin : g_no_md
    assign md_busy = 1'b0;
    assign md_done = 1'b0;
    assign md_lo   = '0;
    assign md_hi   = '0;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a negedge monitor checks them.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid0;
  logic        in_ready, in_ready0;
  logic [3:0]  func;
  logic [15:0] a, b, imm_val;
  logic        imm;
  logic [15:0] out, out0;
  logic        out_valid, out_valid0;
  logic [7:0]  status_reg, status0;

  typedef struct {
    logic [15:0] out;
    logic [7:0]  st;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.WIDTH(16), .MULDIV_EN(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .func(func),
    .a(a), .b(b), .imm(imm), .imm_val(imm_val), .out(out), .out_valid(out_valid),
    .status_reg(status_reg)
  );

  alu_seq #(.WIDTH(16), .MULDIV_EN(0)) u_dut_nomd (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .func(func),
    .a(a), .b(b), .imm(imm), .imm_val(imm_val), .out(out0), .out_valid(out_valid0),
    .status_reg(status0)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected out_valid: got out %h status %h, expected none", out, status_reg);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out", 32'(out), 32'(e.out));
        chk("status", 32'(status_reg), 32'(e.st));
        chk("latency cycle", 32'(cyc), 32'(e.cyc));
        chk("in_ready at completion", 32'(in_ready), 32'd1);
      end
    end
  end

  task automatic issue(input logic [3:0] f, input logic [15:0] av, input logic [15:0] bv,
                       input logic im, input logic [15:0] iv, input logic [15:0] eo,
                       input logic [7:0] es, input int lat, input bit push);
    int n;
    exp_t e;
    @(negedge clk);
    func = f; a = av; b = bv; imm = im; imm_val = iv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready timeout", 32'(in_ready), 32'd1);
    if (push) begin
      e.out = eo; e.st = es; e.cyc = cyc + lat;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0;
    func = '0; a = '0; b = '0; imm = 1'b0; imm_val = '0;
    repeat (2) @(negedge clk);
    chk("reset out", 32'(out), 32'd0);
    chk("reset status", 32'(status_reg), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // Back-to-back compares, one per cycle.
    issue(OP_SUB, 16'd4, 16'd3, 1'b0, 16'h0, 16'h0001, 8'h04, 1, 1'b1);
    issue(OP_SUB, 16'd5, 16'd5, 1'b0, 16'h0, 16'h0000, 8'h05, 1, 1'b1);
    issue(OP_SUB, 16'd2, 16'd6, 1'b0, 16'h0, 16'hFFFC, 8'h02, 1, 1'b1);
    // Immediate operand path.
    issue(OP_PASS, 16'h0000, 16'hDEAD, 1'b1, 16'h1200, 16'h1200, 8'h00, 1, 1'b1);
    issue(OP_OR,   16'h1200, 16'hDEAD, 1'b1, 16'h0034, 16'h1234, 8'h00, 1, 1'b1);
    // Logic and shifts, including a zero shift amount.
    issue(OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 16'h0, 16'h00F0, 8'h00, 1, 1'b1);
    issue(OP_XOR, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0, 16'h0000, 8'h01, 1, 1'b1);
    issue(OP_SHL, 16'h8001, 16'h0001, 1'b0, 16'h0, 16'h0002, 8'h04, 1, 1'b1);
    issue(OP_SHL, 16'h1234, 16'h0010, 1'b0, 16'h0, 16'h1234, 8'h00, 1, 1'b1);
    issue(OP_SHR, 16'h0003, 16'h0001, 1'b0, 16'h0, 16'h0001, 8'h04, 1, 1'b1);
    issue(OP_SRA, 16'h8000, 16'h0004, 1'b0, 16'h0, 16'hF800, 8'h02, 1, 1'b1);
    issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h0, 16'h8000, 8'h0A, 1, 1'b1);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0, 16'h0000, 8'h05, 1, 1'b1);
    issue(4'd14,  16'h1234, 16'h5678, 1'b0, 16'h0, 16'h0000, 8'h20, 1, 1'b1);

    // Multiply / divide.
    issue(OP_MUL, 16'h0100, 16'h0100, 1'b0, 16'h0, 16'h0000, 8'h05, 17, 1'b1);
    @(negedge clk);
    chk("in_ready low while busy", 32'(in_ready), 32'd0);
    issue(OP_MULH, 16'h0100, 16'h0100, 1'b0, 16'h0, 16'h0001, 8'h04, 17, 1'b1);
    issue(OP_DIV, 16'd100, 16'd7, 1'b0, 16'h0, 16'h000E, 8'h00, 17, 1'b1);
    issue(OP_REM, 16'd100, 16'd7, 1'b0, 16'h0, 16'h0002, 8'h00, 17, 1'b1);
    issue(OP_DIV, 16'd9, 16'd0, 1'b0, 16'h0, 16'hFFFF, 8'h12, 1, 1'b1);
    issue(OP_REM, 16'd9, 16'd0, 1'b0, 16'h0, 16'h0009, 8'h10, 1, 1'b1);
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0, 16'h0001, 8'h04, 17, 1'b1);
    idle();
    drain();

    // Reset in the middle of a multiply discards it.
    issue(OP_MUL, 16'h0003, 16'h0005, 1'b0, 16'h0, 16'h0, 8'h0, 17, 1'b0);
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid-op reset out", 32'(out), 32'd0);
    chk("mid-op reset status", 32'(status_reg), 32'd0);
    chk("mid-op reset in_ready", 32'(in_ready), 32'd1);
    chk("mid-op reset out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(OP_ADD, 16'd1, 16'd1, 1'b0, 16'h0, 16'h0002, 8'h00, 1, 1'b1);
    idle();
    drain();

    // With multiply/divide disabled, MUL is illegal and single-cycle.
    @(negedge clk);
    func = OP_MUL; a = 16'd3; b = 16'd4; imm = 1'b0; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    chk("nomd out_valid", 32'(out_valid0), 32'd1);
    chk("nomd out", 32'(out0), 32'd0);
    chk("nomd status", 32'(status0), 32'h20);
    chk("nomd in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk);
    chk("nomd single pulse", 32'(out_valid0), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard empty at end", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
